// File: rtl/spi_slave_shift_reg.sv
// spi_slave_shift_reg: SPI target-side shift engine with oversampled pad inputs,
// a TX holding buffer and an RX valid/ack handshake towards the host side.
// Build option: define SPI_SLAVE_TX_DBUF_EN for a 2-entry TX FIFO; default is a
// single TX holding register.
module spi_slave_shift_reg #(
  parameter int unsigned SPI_MAX_CHAR      = 8,
  parameter int unsigned SPI_CHAR_LEN_BITS = 3
) (
  input  logic                         wb_clk_in,
  input  logic                         wb_rst,
  input  logic                         sclk_pad_i,
  input  logic                         ss_pad_i,
  input  logic                         mosi_pad_i,
  output logic                         miso_pad_o,
  output logic                         miso_oe_o,
  input  logic                         cpol,
  input  logic                         cpha,
  input  logic                         lsb,
  input  logic [SPI_CHAR_LEN_BITS-1:0] len,
  input  logic [SPI_MAX_CHAR-1:0]      tx_data,
  input  logic                         tx_load,
  output logic                         tx_ready,
  output logic                         tx_underrun,
  output logic [SPI_MAX_CHAR-1:0]      rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ack,
  output logic                         rx_overrun,
  output logic                         tip
);

  localparam int unsigned CNT_W = $clog2(SPI_MAX_CHAR + 1);
  localparam int unsigned IDX_W = (SPI_MAX_CHAR > 1) ? $clog2(SPI_MAX_CHAR) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [1:0]              sclk_sync;
  logic [1:0]              ss_sync;
  logic [1:0]              mosi_sync;
  logic                    sclk_hist;
  logic                    ss_hist;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    ss_fall;
  logic                    sample_edge;
  logic                    shift_edge;
  logic [CNT_W-1:0]        char_len;
  logic [SPI_MAX_CHAR-1:0] char_mask;
  logic [CNT_W-1:0]        bit_cnt;
  logic [SPI_MAX_CHAR-1:0] tx_sr;
  logic [SPI_MAX_CHAR-1:0] rx_sr;
  logic                    do_load;
  logic                    do_done;
  logic                    do_abort;
  logic                    do_sample;
  logic                    do_shift;
  logic                    tx_pop;
  logic                    tx_accept;
  logic                    tx_pop_ok;
  logic                    tx_avail;
  logic [SPI_MAX_CHAR-1:0] tx_head;
  logic [SPI_MAX_CHAR-1:0] pop_word;

  // Wire position of the seq-th transmitted/received bit of an n-bit character
  function automatic logic [IDX_W-1:0] bit_pos(input logic [CNT_W-1:0] seq,
                                               input logic             lsb_first,
                                               input logic [CNT_W-1:0] n);
    logic [CNT_W-1:0] p;
    p = lsb_first ? seq : (n - CNT_W'(1) - seq);
    return IDX_W'(p);
  endfunction

  // Pad synchronisers plus history flops for edge detection
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      sclk_sync <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_hist <= 1'b0;
      ss_hist   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk_pad_i};
      ss_sync   <= {ss_sync[0], ss_pad_i};
      mosi_sync <= {mosi_sync[0], mosi_pad_i};
      sclk_hist <= sclk_sync[1];
      ss_hist   <= ss_sync[1];
    end
  end

  assign sclk_rise   = sclk_sync[1] & ~sclk_hist;
  assign sclk_fall   = ~sclk_sync[1] & sclk_hist;
  assign ss_fall     = ~ss_sync[1] & ss_hist;
  assign sample_edge = (cpol == cpha) ? sclk_rise : sclk_fall;
  assign shift_edge  = (cpol == cpha) ? sclk_fall : sclk_rise;
  assign char_len    = (len == '0) ? CNT_W'(SPI_MAX_CHAR) : CNT_W'(len);

  // Received bits at or above the character length read as zero
  always_comb begin
    char_mask = '0;
    for (int i = 0; i < int'(SPI_MAX_CHAR); i++) begin
      char_mask[i] = (CNT_W'(i) < char_len);
    end
  end

  // Frame state register
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Frame next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (ss_fall) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (ss_sync[1]) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Per-cycle datapath strobes decoded from the frame state
  always_comb begin
    do_load   = 1'b0;
    do_done   = 1'b0;
    do_abort  = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    case (state)
      ST_LOAD: do_load = 1'b1;
      ST_ACTIVE: begin
        if (ss_sync[1])               do_abort = 1'b1;
        else if (bit_cnt == char_len) do_done  = 1'b1;
        else begin
          do_sample = sample_edge;
          do_shift  = shift_edge;
        end
      end
      default: ;
    endcase
  end

  assign tx_pop    = do_load | do_done;
  assign tx_accept = tx_load & tx_ready;
  assign tx_pop_ok = tx_pop & tx_avail;
  assign pop_word  = tx_avail ? tx_head : '0;

`ifdef SPI_SLAVE_TX_DBUF_EN
  logic [1:0]              tx_occ;
  logic [1:0]              tx_occ_nxt;
  logic [SPI_MAX_CHAR-1:0] tx_q0;
  logic [SPI_MAX_CHAR-1:0] tx_q1;

  assign tx_avail   = (tx_occ != 2'd0);
  assign tx_head    = tx_q0;
  assign tx_occ_nxt = tx_occ + 2'(tx_accept) - 2'(tx_pop_ok);

  // Two-entry TX FIFO; a write lands behind whatever survives this cycle's pop
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      tx_occ   <= 2'd0;
      tx_q0    <= '0;
      tx_q1    <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (tx_pop_ok) tx_q0 <= tx_q1;
      if (tx_accept) begin
        if ((tx_occ - 2'(tx_pop_ok)) == 2'd0) tx_q0 <= tx_data;
        else                                  tx_q1 <= tx_data;
      end
      tx_occ   <= tx_occ_nxt;
      tx_ready <= (tx_occ_nxt != 2'd2);
    end
  end
`else
  logic                    tx_full;
  logic [SPI_MAX_CHAR-1:0] tx_hold;

  assign tx_avail = tx_full;
  assign tx_head  = tx_hold;

  // Single TX holding register; accept needs it empty, pop needs it full
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      tx_full  <= 1'b0;
      tx_hold  <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (tx_accept) begin
        tx_hold  <= tx_data;
        tx_full  <= 1'b1;
        tx_ready <= 1'b0;
      end else if (tx_pop_ok) begin
        tx_full  <= 1'b0;
        tx_ready <= 1'b1;
      end
    end
  end
`endif

  // Shift engine, RX handshake and status flags
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      miso_pad_o  <= 1'b0;
      miso_oe_o   <= 1'b0;
      tip         <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tip       <= (state_nxt != ST_IDLE);
      miso_oe_o <= (state_nxt != ST_IDLE);
      if (tx_accept)           tx_underrun <= 1'b0;
      if (tx_pop && !tx_avail) tx_underrun <= 1'b1;
      if (rx_ack) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (tx_pop) begin
        tx_sr   <= pop_word;
        rx_sr   <= '0;
        bit_cnt <= '0;
        if (!cpha) miso_pad_o <= pop_word[bit_pos(CNT_W'(0), lsb, char_len)];
      end
      if (do_done) begin
        if (rx_valid && !rx_ack) begin
          rx_overrun <= 1'b1;
        end else begin
          rx_data  <= rx_sr & char_mask;
          rx_valid <= 1'b1;
        end
      end
      if (do_sample) begin
        rx_sr[bit_pos(bit_cnt, lsb, char_len)] <= mosi_sync[1];
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      // bit_cnt already names the next bit: 0 on the leading cpha=1 edge
      if (do_shift) miso_pad_o <= tx_sr[bit_pos(bit_cnt, lsb, char_len)];
      if (do_abort) begin
        bit_cnt    <= '0;
        rx_sr      <= '0;
        miso_pad_o <= 1'b0;
      end
    end
  end

endmodule
